// File: rtl/bp_pkg.sv
// Shared branch-predictor types: history width, history word and the
// per-branch snapshot entry held while a prediction is in flight.
package bp_pkg;
  localparam int HIST_W = 12;

  typedef logic [HIST_W-1:0] hist_t;

  typedef struct packed {
    hist_t snap;
    logic  pred;
  } phu_entry_t;

  localparam logic [15:0] MISPRED_CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/phu_snapshot_fifo.sv
// DEPTH-entry FIFO of history snapshots. Flush wins over push and pop;
// occupancy is kept in its own counter so full/empty need no pointer compare.
module phu_snapshot_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  phu_entry_t               i_push_data,
  input  logic                     i_pop,
  output phu_entry_t               o_pop_data,
  input  logic                     i_flush,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  phu_entry_t          r_mem [DEPTH];
  logic [AW-1:0]       r_rd, r_wr;
  logic [AW:0]         r_cnt;
  logic                w_do_push, w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_pop_data = r_mem[r_rd];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= r_wr;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never read while empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr] <= i_push_data;
  end
endmodule

// File: rtl/path_history_unit.sv
// Speculative/committed global path history with snapshot-based repair.
// Optional mispredict counter enabled by defining PHU_MISPRED_CNT_EN.
module path_history_unit
  import bp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_predict_valid,
  input  logic                   i_predict_taken,
  output logic                   o_predict_ready,
  input  logic                   i_resolve_valid,
  input  logic                   i_resolve_taken,
  output hist_t                  o_spec_history,
  output hist_t                  o_commit_history,
  output logic [$clog2(DEPTH):0] o_inflight,
  output logic                   o_empty,
`ifdef PHU_MISPRED_CNT_EN
  output logic [15:0]            o_mispred_count,
`endif
  output logic                   o_mispredict
);
  hist_t      r_spec, r_commit;
  logic       r_mispredict;
  phu_entry_t w_head, w_push_data;
  logic       w_full, w_empty, w_pop, w_repair, w_push;

  assign w_pop       = i_resolve_valid && !w_empty;
  assign w_repair    = w_pop && (i_resolve_taken != w_head.pred);
  // A push colliding with a repair is on the wrong path and is discarded.
  assign w_push      = i_predict_valid && !w_full && !w_repair;
  assign w_push_data = '{snap: r_spec, pred: i_predict_taken};

  phu_snapshot_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .i_flush     (w_repair),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (o_inflight)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spec       <= '0;
      r_commit     <= '0;
      r_mispredict <= 1'b0;
    end else begin
      if (w_repair)    r_spec <= hist_t'({w_head.snap, i_resolve_taken});
      else if (w_push) r_spec <= hist_t'({r_spec, i_predict_taken});
      if (w_pop)       r_commit <= hist_t'({r_commit, i_resolve_taken});
      r_mispredict <= w_repair;
    end
  end

`ifdef PHU_MISPRED_CNT_EN
  logic [15:0] r_mis_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                     r_mis_cnt <= '0;
    else if (w_repair && r_mis_cnt != MISPRED_CNT_MAX) r_mis_cnt <= r_mis_cnt + 16'd1;
  end
  assign o_mispred_count = r_mis_cnt;
`endif

  assign o_predict_ready  = !w_full;
  assign o_spec_history   = r_spec;
  assign o_commit_history = r_commit;
  assign o_empty          = w_empty;
  assign o_mispredict     = r_mispredict;
endmodule

// File: tb/tb_path_history_unit.sv
// Bench for path_history_unit: directed scenarios then random traffic,
// all checked against a queue-based reference model.
module tb_path_history_unit;
  import bp_pkg::*;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << HIST_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pv = 1'b0, pt = 1'b0, rv = 1'b0, rt = 1'b0;
  logic ready, empty, mis;
  hist_t spec, commit;
  logic [$clog2(DEPTH):0] inflight;
`ifdef PHU_MISPRED_CNT_EN
  logic [15:0] mcnt;
`endif

  path_history_unit #(.DEPTH(DEPTH)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_predict_valid  (pv),
    .i_predict_taken  (pt),
    .o_predict_ready  (ready),
    .i_resolve_valid  (rv),
    .i_resolve_taken  (rt),
    .o_spec_history   (spec),
    .o_commit_history (commit),
    .o_inflight       (inflight),
    .o_empty          (empty),
`ifdef PHU_MISPRED_CNT_EN
    .o_mispred_count  (mcnt),
`endif
    .o_mispredict     (mis)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  typedef struct { int snap; bit pred; } ent_t;
  ent_t m_q[$];
  int   m_spec, m_commit, m_cnt;
  bit   m_mis;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_spec = 0; m_commit = 0; m_cnt = 0; m_mis = 0;
  endfunction

  // One clock of the architectural rules: in-order resolve, repair flushes.
  function automatic void model_clk(bit p_v, bit p_t, bit r_v, bit r_t);
    bit pop, rep, push;
    ent_t e;
    pop  = r_v && (m_q.size() > 0);
    rep  = pop && (r_t != m_q[0].pred);
    push = p_v && (m_q.size() < DEPTH) && !rep;
    if (pop) m_commit = ((m_commit << 1) | int'(r_t)) & MASK;
    if (rep) begin
      m_spec = ((m_q[0].snap << 1) | int'(r_t)) & MASK;
      m_q.delete();
      if (m_cnt < 65535) m_cnt++;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        e.snap = m_spec; e.pred = p_t;
        m_q.push_back(e);
        m_spec = ((m_spec << 1) | int'(p_t)) & MASK;
      end
    end
    m_mis = rep;
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".spec"},     32'(spec),     32'(m_spec));
    chk({ph, ".commit"},   32'(commit),   32'(m_commit));
    chk({ph, ".inflight"}, 32'(inflight), 32'(m_q.size()));
    chk({ph, ".empty"},    32'(empty),    32'(m_q.size() == 0));
    chk({ph, ".ready"},    32'(ready),    32'(m_q.size() < DEPTH));
    chk({ph, ".mispred"},  32'(mis),      32'(m_mis));
`ifdef PHU_MISPRED_CNT_EN
    chk({ph, ".mcnt"},     32'(mcnt),     32'(m_cnt));
`endif
    if (empty && !mis) chk({ph, ".invariant"}, 32'(spec), 32'(commit));
  endtask

  task automatic step(input bit p_v, input bit p_t, input bit r_v, input bit r_t, input string ph);
    pv = p_v; pt = p_t; rv = r_v; rt = r_t;
    @(posedge clk);
    model_clk(p_v, p_t, r_v, r_t);
    #1;
    check_all(ph);
  endtask

  // Asserts reset between edges; outputs must react before the next edge.
  task automatic do_reset(input string ph);
    #1 rst_n = 1'b0;
    pv = 0; rv = 0;
    #1;
    model_reset();
    check_all(ph);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    bit bp, bt, br, brt;
    @(posedge clk); #1;
    do_reset("por");
    chk("por.spec0", 32'(spec), 32'h0);
    chk("por.ready1", 32'(ready), 32'h1);

    // Basic push then in-order correct resolves
    step(1, 1, 0, 0, "bp"); step(1, 1, 0, 0, "bp"); step(1, 0, 0, 0, "bp");
    chk("bp.spec006", 32'(spec), 32'h006);
    chk("bp.infl3", 32'(inflight), 32'd3);
    step(0, 0, 1, 1, "cr"); step(0, 0, 1, 1, "cr"); step(0, 0, 1, 0, "cr");
    chk("cr.commit006", 32'(commit), 32'h006);
    chk("cr.empty1", 32'(empty), 32'h1);

    // Repair
    do_reset("rst1");
    step(1, 1, 0, 0, "rp"); step(1, 0, 0, 0, "rp"); step(1, 1, 0, 0, "rp");
    chk("rp.spec005", 32'(spec), 32'h005);
    step(0, 0, 1, 1, "rp");
    chk("rp.commit001", 32'(commit), 32'h001);
    step(0, 0, 1, 1, "rp");
    chk("rp.spec003", 32'(spec), 32'h003);
    chk("rp.commit003", 32'(commit), 32'h003);
    chk("rp.infl0", 32'(inflight), 32'd0);
    chk("rp.mis1", 32'(mis), 32'h1);
`ifdef PHU_MISPRED_CNT_EN
    chk("rp.mcnt1", 32'(mcnt), 32'd1);
`endif
    step(0, 0, 0, 0, "rp");
    chk("rp.mis0", 32'(mis), 32'h0);

    // Full
    do_reset("rst2");
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, "full");
    chk("full.ready0", 32'(ready), 32'h0);
    step(1, 0, 0, 0, "full9");
    chk("full9.spec", 32'(spec), 32'h0FF);
    step(1, 0, 1, 1, "fullpp");
    chk("fullpp.infl7", 32'(inflight), 32'd7);

    // Resolve on empty, then push colliding with a repair
    do_reset("rst3");
    step(0, 0, 1, 1, "remp");
    chk("remp.commit0", 32'(commit), 32'h0);
    chk("remp.mis0", 32'(mis), 32'h0);
    step(1, 0, 0, 0, "pr");
    step(1, 1, 1, 1, "pr");
    chk("pr.infl0", 32'(inflight), 32'd0);
    chk("pr.spec001", 32'(spec), 32'h001);

    // Async reset mid-stream
    step(1, 1, 0, 0, "ar"); step(1, 0, 0, 0, "ar");
    do_reset("arst");
    chk("arst.empty1", 32'(empty), 32'h1);
    step(1, 1, 0, 0, "ar2");
    chk("ar2.spec001", 32'(spec), 32'h001);

    // Random traffic; resolves mostly agree with the prediction
    for (int n = 0; n < 3000; n++) begin
      bp = ($urandom_range(0, 3) != 0);
      bt = $urandom_range(0, 1);
      br = ($urandom_range(0, 2) != 0);
      if (m_q.size() > 0 && $urandom_range(0, 4) != 0) brt = m_q[0].pred;
      else brt = $urandom_range(0, 1);
      step(bp, bt, br, brt, "rnd");
      if ($urandom_range(0, 499) == 0) do_reset("rrst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/path_history_unit.md
# path_history_unit

Upstream path-history stage of the tournament branch predictor. Maintains a speculative global path history that indexes the global 2-bit counter table at fetch, and an in-order committed history. An in-flight snapshot FIFO allows exact history repair on a branch mispredict. One prediction push and one resolve pop may occur per cycle.

## Interface
- HIST_W, 12, history length; equals the global predictor index width.
- DEPTH, 8, max in-flight unresolved branches; must be a power of 2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- predict_valid  in  1  fetch presents a predicted conditional branch.
- predict_taken  in  1  predicted direction.
- predict_ready  out  1  `!full`; push occurs only when valid && ready.
- resolve_valid  in  1  oldest in-flight branch resolves; strictly in order.
- resolve_taken  in  1  actual direction.
- spec_history  out  HIST_W  speculative history; drives the global predictor PathHistory input.
- commit_history  out  HIST_W  history of resolved branches.
- inflight  out  $clog2(DEPTH)+1  FIFO occupancy.
- empty  out  1  inflight == 0.
- mispredict  out  1  registered one-cycle pulse, high the cycle after a repair.

## Operation
- **Push** (predict_valid && predict_ready && no repair this cycle):
  - enqueue {snap = spec_history before shift, pred = predict_taken};
  - spec_history <= {spec_history[HIST_W-2:0], predict_taken}.
- **Pop** (resolve_valid && !empty):
  - dequeue the oldest entry;
  - commit_history <= {commit_history[HIST_W-2:0], resolve_taken}.
- **Correct resolve** (resolve_taken == pred): spec_history is untouched by the pop.
- **Repair** (resolve_taken != pred):
  - spec_history <= {snap[HIST_W-2:0], resolve_taken};
  - FIFO flushed (rd = wr, inflight = 0);
  - mispredict = 1 next cycle.
- **Push and repair in the same cycle:** the push is dropped (wrong-path branch). Neither the FIFO nor spec_history sees it.
- **Resolve while empty:** ignored; no state change, no mispredict.
- **Push and pop while full:** the push is refused because predict_ready = 0. Occupancy becomes DEPTH-1.
- **Push and correct pop while not full:** both take effect; occupancy is unchanged.
- **Pointer arithmetic:** rd/wr pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy uses a separate counter.
- **Invariant (checked by bench):** whenever empty is high and mispredict is low, spec_history == commit_history.

## Timing
- **Reset values:**
  - spec_history = 0, commit_history = 0, inflight = 0;
  - empty = 1, predict_ready = 1, mispredict = 0.
- Reset takes effect immediately on assertion, mid-operation included. The FIFO contents become don't-care.
- The global predictor samples spec_history in the push cycle (pre-shift value). The shifted value is visible one cycle later.
- **Output sourcing:**
  - commit_history, inflight, empty and mispredict are registered; latency 1.
  - predict_ready is a combinational decode of registered occupancy only. There is no path from the resolve inputs.

## Configuration
- **PHU_MISPRED_CNT_EN defined:**
  - adds output mispred_count [15:0];
  - increments once per repair and saturates at 0xFFFF;
  - reset to 0.
- **PHU_MISPRED_CNT_EN undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Package bp_pkg:**
  - localparam HIST_W = 12;
  - typedef logic [HIST_W-1:0] hist_t;
  - typedef struct packed {hist_t snap; logic pred;} phu_entry_t.
- **Sub-module phu_snapshot_fifo:**
  - generic DEPTH-entry phu_entry_t FIFO;
  - ports: push, pop, flush, full, empty, count;
  - flush has priority over push.
- The top level holds the two history registers, repair logic and optional counter.

## Test plan
- **Basic push:** reset, push T,T,N → spec_history 0x006, inflight 3, commit_history 0x000, mispredict never high.
- **Correct resolves:** continue with resolve T,T,N → commit_history 0x006, empty 1, spec_history 0x006 (invariant holds).
- **Repair:**
  - from reset, push T,N,T (spec 0x005); resolve T → commit 0x001;
  - resolve T against the N prediction → spec_history 0x003, commit 0x003, inflight 0, mispredict pulse one cycle.
- **Full:**
  - 8 pushes → predict_ready 0; a 9th push is ignored (spec unchanged);
  - push + correct pop at full → inflight 7.
- **Edge events:**
  - resolve on empty → no change;
  - push in the same cycle as a repair → dropped, inflight 0 afterwards;
  - with PHU_MISPRED_CNT_EN, mispred_count increments by 1 per repair.
- **Async reset:** assert reset mid-stream between clock edges → all outputs show reset values before the next edge; after release, a push T → spec 0x001.
